line_mem_responder: RTL and testbench
=====================================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LINES, default 1024, number of 128-bit lines stored; power of two, at least 2.
REQ-002 SHALL have parameter LATENCY, default 3, cycles from request accept to response; range 1..15.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port cs_i, input, 1, request valid from the initiator; held high until rvalid_o is seen.
REQ-006 SHALL have port we_i, input, 1, 1 = line write, 0 = line read.
REQ-007 SHALL have port addr_i, input, 32, byte address; addr_i[3:0] ignored; line index = addr_i[4+log2(DEPTH_LINES)-1:4].
REQ-008 SHALL have port wdata_i, input, 128, write line data.
REQ-009 SHALL have port rdata_o, output, 128, response line data.
REQ-010 SHALL have port rvalid_o, output, 1, one-cycle response pulse, for reads and writes.
REQ-011 SHALL have port busy_o, output, 1, high while a request is in flight.
REQ-012 SHALL have port err_o, output, 1, response error flag, qualified by rvalid_o.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and RESP.
REQ-014 IDLE: on an edge with cs_i=1, SHALL capture we_i, addr_i and wdata_i, load the latency counter with LATENCY-1, and go to RESP if LATENCY=1, else BUSY.
REQ-015 BUSY: counter decrements each edge; SHALL go to RESP on the edge where the counter is 0; busy_o=1 in BUSY and RESP.
REQ-016 RESP: rvalid_o=1 for exactly one cycle, LATENCY cycles after the accept edge; next state always IDLE.
REQ-017 Read: rdata_o SHALL equal the line at the captured index during the rvalid_o cycle.
REQ-018 Write: the captured wdata SHALL be committed on the edge entering RESP; rdata_o SHALL echo the written line during rvalid_o.
REQ-019 rdata_o and err_o SHALL be registered and hold their value until the next response.
REQ-020 addr_i, we_i and wdata_i changes after the accept edge SHALL be ignored.
REQ-021 cs_i falling during BUSY SHALL NOT abort the request; the write still commits and rvalid_o still pulses.
REQ-022 cs_i still high in the IDLE cycle after rvalid_o SHALL be accepted as a new request; the initiator deasserts cs_i combinationally on rvalid_o.
REQ-023 A read of a line in the cycle after a write to it completes SHALL return the new data.
REQ-024 Sustained throughput SHALL be one request per LATENCY+1 cycles.
REQ-025 Storage SHALL be a single-port array of DEPTH_LINES x 128 bits with no byte enables.

Reset
REQ-026 While rst_i=1, the block SHALL hold state IDLE, counter 0, rvalid_o=0, busy_o=0, err_o=0 and rdata_o=0.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 Reset during BUSY SHALL discard the request, with no write commit and no rvalid_o.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_i falls.

Configuration
REQ-030 Macro LINE_MEM_RESP_ERR_EN defined: a line index at or beyond DEPTH_LINES, using addr_i[31:4] as a full index, SHALL give err_o=1 with rvalid_o, rdata_o=0, and the write suppressed.
REQ-031 Macro undefined: upper address bits SHALL be ignored so the index wraps modulo DEPTH_LINES, and err_o SHALL be tied to 0.

Verification (LATENCY=3, DEPTH_LINES=1024)
REQ-032 Write 0x00000010 with data 0x0123..CDEF, then read the same address -> rvalid_o 3 cycles after each accept; read rdata_o=0x0123..CDEF.
REQ-033 Read 0x0000001C -> returns the line at index 1, because offset bits are ignored.
REQ-034 Drop cs_i one cycle after a write accept -> rvalid_o still pulses on cycle 3 and the data is committed.
REQ-035 Assert rst_i on cycle 2 of a write -> no rvalid_o, and the following read shows the old contents.
REQ-036 Write 0x00004000 -> with the macro: err_o=1 and line 0 unchanged; without the macro: line 0 is overwritten.
REQ-037 Hold cs_i high continuously -> rvalid_o pulses every 4 cycles and busy_o drops for exactly 1 cycle between requests.

Source files
------------

// File: rtl/line_mem_responder.sv
// line_mem_responder: fixed-latency single-port 128-bit line memory answering one request at a time
// Ports: clk_i/rst_i clock and async active-high reset; cs_i/we_i/addr_i/wdata_i request held until rvalid_o;
//        rdata_o/err_o registered response qualified by the one-cycle rvalid_o pulse; busy_o high while in flight.
// Macro LINE_MEM_RESP_ERR_EN: out-of-range line index answers err_o=1, rdata_o=0 and drops the write;
//        undefined, the index wraps modulo DEPTH_LINES and err_o stays 0.
module line_mem_responder #(
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cs_i,
    input  logic         we_i,
    input  logic [31:0]  addr_i,
    input  logic [127:0] wdata_i,
    output logic [127:0] rdata_o,
    output logic         rvalid_o,
    output logic         busy_o,
    output logic         err_o
);
    localparam int AW = $clog2(DEPTH_LINES);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t         state;
    logic [3:0]     cnt;
    logic           cap_we, cap_err;
    logic [AW-1:0]  cap_idx;
    logic [127:0]   cap_wdata;
    logic [127:0]   mem [DEPTH_LINES];
    logic           in_err, accept, enter_resp, commit;
    logic           go_we, go_err;
    logic [AW-1:0]  go_idx;
    logic [127:0]   go_wdata;
    logic           unused_addr;
`ifdef LINE_MEM_RESP_ERR_EN
    assign in_err      = {4'b0, addr_i[31:4]} >= 32'(DEPTH_LINES);
    assign unused_addr = ^addr_i[3:0];
`else
    assign in_err      = 1'b0;
    assign unused_addr = ^{addr_i[3:0], addr_i[31:4+AW]};
`endif
    // With LATENCY=1 the response is entered on the accept edge itself, so the
    // request fields come straight from the inputs rather than the capture registers.
    always_comb begin
        accept     = state == IDLE && cs_i;
        enter_resp = (accept && LATENCY == 1) || (state == BUSY && cnt == 4'd1);
        go_we      = accept ? we_i : cap_we;
        go_err     = accept ? in_err : cap_err;
        go_idx     = accept ? addr_i[4 +: AW] : cap_idx;
        go_wdata   = accept ? wdata_i : cap_wdata;
        commit     = enter_resp && go_we && !go_err;
    end
    always_ff @(posedge clk_i) begin
        if (commit) mem[go_idx] <= go_wdata;
    end
    // The counter reaches 0 on the same edge that enters RESP, giving LATENCY
    // cycles to rvalid_o and one IDLE cycle between back-to-back requests.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rvalid_o  <= 1'b0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
            cap_we    <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
        end else begin
            rvalid_o <= enter_resp;
            busy_o   <= accept || state == BUSY;
            if (accept) begin
                cap_we    <= we_i;
                cap_err   <= in_err;
                cap_idx   <= addr_i[4 +: AW];
                cap_wdata <= wdata_i;
                cnt       <= 4'(LATENCY - 1);
                state     <= LATENCY == 1 ? RESP : BUSY;
            end else if (state == BUSY) begin
                cnt   <= cnt - 4'd1;
                state <= cnt == 4'd1 ? RESP : BUSY;
            end else if (state == RESP) begin
                state <= IDLE;
            end
            if (enter_resp) begin
                rdata_o <= go_err ? '0 : go_we ? go_wdata : mem[go_idx];
                err_o   <= go_err;
            end
        end
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// tb_line_mem_responder: table vectors plus corner sequences, responses checked through an expected-value queue
module tb_line_mem_responder;
    localparam int LAT = 3;
    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
    localparam logic [127:0] D3 = 128'hFFFF0000_FFFF0000_AAAA5555_AAAA5555;
    localparam logic [127:0] D4 = 128'h00000000_11111111_22222222_33333333;
    localparam logic [127:0] D5 = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;
    localparam logic [127:0] D6 = 128'h66666666_66666666_66666666_66666666;
    localparam logic [127:0] D7 = 128'h77777777_88888888_99999999_AAAAAAAA;
    logic         clk = 1'b0, rst = 1'b1, cs = 1'b0, we = 1'b0;
    logic [31:0]  addr = '0;
    logic [127:0] wdata = '0;
    logic [127:0] rdata;
    logic         rvalid, busy, err;
    int checks = 0, errors = 0, rv_cnt = 0;
    typedef struct packed {logic [127:0] d; logic e;} exp_t;
    exp_t sb[$];
    typedef struct {logic w; logic [31:0] a; logic [127:0] d; logic [127:0] ed; logic ee;} vec_t;
    vec_t tv[9];

    line_mem_responder #(.DEPTH_LINES(1024), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst), .cs_i(cs), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata), .rvalid_o(rvalid), .busy_o(busy), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!rst && rvalid) begin
            rv_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid rdata %h err %b", rdata, err);
            end else begin
                x = sb.pop_front();
                chk("rdata", rdata, x.d);
                chk("err", 128'(err), 128'(x.e));
            end
        end
    end

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (busy && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("idle_timeout", 128'(busy), 128'(0));
    endtask

    task automatic do_req(input logic w, input logic [31:0] a, input logic [127:0] d,
                          input logic [127:0] ed, input logic ee, input bit drop);
        int cyc;
        wait_idle();
        cs = 1'b1; we = w; addr = a; wdata = d;
        sb.push_back('{d: ed, e: ee});
        @(posedge clk); #1;
        cyc = 1;
        chk("busy_inflight", 128'(busy), 128'(1));
        if (drop) begin
            cs = 1'b0; we = ~w; addr = ~a; wdata = ~d;
        end
        while (!rvalid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        cs = 1'b0;
        chk("latency", 128'(cyc), 128'(LAT));
    endtask

    initial begin
        int n, t, low;
        int tp[3];
        tv[0] = '{1'b1, 32'h0000_0010, D1, D1, 1'b0};
        tv[1] = '{1'b0, 32'h0000_0010, '0, D1, 1'b0};
        tv[2] = '{1'b0, 32'h0000_001C, '0, D1, 1'b0};
        tv[3] = '{1'b1, 32'h0000_0020, D2, D2, 1'b0};
        tv[4] = '{1'b0, 32'h0000_0020, '0, D2, 1'b0};
        tv[5] = '{1'b1, 32'h0000_3FF0, D3, D3, 1'b0};
        tv[6] = '{1'b0, 32'h0000_3FF0, '0, D3, 1'b0};
        tv[7] = '{1'b1, 32'h0000_0000, D4, D4, 1'b0};
        tv[8] = '{1'b0, 32'h0000_0000, '0, D4, 1'b0};
        repeat (2) @(negedge clk);
        chk("rst_rvalid", 128'(rvalid), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_rdata", rdata, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 9; i++) do_req(tv[i].w, tv[i].a, tv[i].d, tv[i].ed, tv[i].ee, 1'b0);
        do_req(1'b1, 32'h0000_0030, D5, D5, 1'b0, 1'b1);
        do_req(1'b0, 32'h0000_0030, '0, D5, 1'b0, 1'b0);
        wait_idle();
        cs = 1'b1; we = 1'b1; addr = 32'h0000_0010; wdata = D6;
        @(posedge clk); #1;
        cs = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 128'(busy), 128'(0));
        chk("rst_mid_rdata", rdata, '0);
        n = rv_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        chk("no_rvalid_after_rst", 128'(rv_cnt), 128'(n));
        do_req(1'b0, 32'h0000_0010, '0, D1, 1'b0, 1'b0);
`ifdef LINE_MEM_RESP_ERR_EN
        do_req(1'b1, 32'h0000_4000, D7, '0, 1'b1, 1'b0);
        do_req(1'b0, 32'h0000_0000, '0, D4, 1'b0, 1'b0);
`else
        do_req(1'b1, 32'h0000_4000, D7, D7, 1'b0, 1'b0);
        do_req(1'b0, 32'h0000_0000, '0, D7, 1'b0, 1'b0);
`endif
        wait_idle();
        cs = 1'b1; we = 1'b0; addr = 32'h0000_0020; wdata = '0;
        for (int i = 0; i < 3; i++) sb.push_back('{d: D2, e: 1'b0});
        n = 0; t = 0; low = 0;
        tp = '{0, 0, 0};
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(posedge clk); #1;
            t++;
            if (!busy) low++;
            if (rvalid) begin
                tp[n] = t;
                n++;
            end
        end
        cs = 1'b0;
        chk("stream_pulses", 128'(n), 128'(3));
        chk("stream_period1", 128'(tp[1] - tp[0]), 128'(LAT + 1));
        chk("stream_period2", 128'(tp[2] - tp[1]), 128'(LAT + 1));
        chk("stream_busy_low", 128'(low), 128'(2));
        repeat (4) @(posedge clk);
        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
